// File: rtl/axi_lite_master_if.sv
// Bundle of the command/response port and the AXI4-Lite master channels for axi_lite_master.
// Valid/ready rule on every channel: a transfer happens on a rising clock edge where valid && ready; valid and payload hold until then.
interface axi_lite_master_if #(
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int M_AXI_ADDR_WIDTH = 4
);
    localparam int SW = M_AXI_DATA_WIDTH / 8;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [M_AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [M_AXI_DATA_WIDTH-1:0] cmd_wdata;
    logic [SW-1:0]               cmd_wstrb;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_write;
    logic [M_AXI_DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]                  rsp_resp;

    logic [M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [2:0]                  m_axi_awprot;
    logic                        m_axi_awvalid;
    logic                        m_axi_awready;
    logic [M_AXI_DATA_WIDTH-1:0] m_axi_wdata;
    logic [SW-1:0]               m_axi_wstrb;
    logic                        m_axi_wvalid;
    logic                        m_axi_wready;
    logic [1:0]                  m_axi_bresp;
    logic                        m_axi_bvalid;
    logic                        m_axi_bready;
    logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [2:0]                  m_axi_arprot;
    logic                        m_axi_arvalid;
    logic                        m_axi_arready;
    logic [M_AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                  m_axi_rresp;
    logic                        m_axi_rvalid;
    logic                        m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or write out, one response back.
// Every output comes from a flop; dbg_state exposes the FSM state for checkers.
module axi_lite_master #(
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int M_AXI_ADDR_WIDTH = 4
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_aresetn,
    axi_lite_master_if.master    bus,
    output logic [2:0]           dbg_state
);
    localparam int SW = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic [M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                        awvalid_q, awvalid_d;
    logic [M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]               wstrb_q, wstrb_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic [M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        rsp_write_q, rsp_write_d;
    logic [M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd_write) begin
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = bus.cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is only requested once both are gone.
                awvalid_d = awvalid_q && !bus.m_axi_awready;
                wvalid_d  = wvalid_q && !bus.m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.m_axi_bresp;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.m_axi_rdata;
                    rsp_resp_d  = bus.m_axi_rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered copy of "next state is IDLE" so cmd_ready is low while in reset.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed commands, a programmable AXI slave model and a response scoreboard.
module tb_axi_lite_master;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         n_rsp = 0;
    int         hs_cyc = 0;

    axi_lite_master_if #(.M_AXI_DATA_WIDTH(DW), .M_AXI_ADDR_WIDTH(AW)) bus ();

    axi_lite_master #(.M_AXI_DATA_WIDTH(DW), .M_AXI_ADDR_WIDTH(AW)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .bus           (bus),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // slave behaviour knobs
    int         aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 1, r_wait = 1;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;
    int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

    // scoreboards
    logic [AW-1:0]    aw_exp_q[$];
    logic [SW+DW-1:0] w_exp_q[$];
    logic [AW-1:0]    ar_exp_q[$];
    logic [DW+2:0]    exp_q[$];
    int               lat_q[$];

    // bus timing monitor state
    int            aw_hi = 0, w_hi = 0, ar_hi = 0;
    int            last_aw_hi = 0, last_w_hi = 0, last_ar_hi = 0;
    logic [AW-1:0] aw_first, ar_first;
    logic [DW-1:0] w_first;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event expected event", name);
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_resp,
                bus.m_axi_awaddr, bus.m_axi_awprot, bus.m_axi_awvalid,
                bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wvalid, bus.m_axi_bready,
                bus.m_axi_araddr, bus.m_axi_arprot, bus.m_axi_arvalid, bus.m_axi_rready};
    endfunction

    // AW channel slave
    initial forever begin
        @(negedge clk);
        if (!rst_n || !bus.m_axi_awvalid) begin
            bus.m_axi_awready = 1'b0;
            aw_cnt = 0;
        end else if (aw_cnt >= aw_wait) begin
            if (!bus.m_axi_awready) begin
                if (aw_exp_q.size() == 0) fail("aw_unexpected");
                else check("awaddr", bus.m_axi_awaddr, aw_exp_q.pop_front());
                check("awprot", bus.m_axi_awprot, 3'b000);
            end
            bus.m_axi_awready = 1'b1;
        end else begin
            bus.m_axi_awready = 1'b0;
            aw_cnt++;
        end
    end

    // W channel slave
    initial forever begin
        @(negedge clk);
        if (!rst_n || !bus.m_axi_wvalid) begin
            bus.m_axi_wready = 1'b0;
            w_cnt = 0;
        end else if (w_cnt >= w_wait) begin
            if (!bus.m_axi_wready) begin
                if (w_exp_q.size() == 0) fail("w_unexpected");
                else check("wstrb_wdata", {bus.m_axi_wstrb, bus.m_axi_wdata}, w_exp_q.pop_front());
            end
            bus.m_axi_wready = 1'b1;
        end else begin
            bus.m_axi_wready = 1'b0;
            w_cnt++;
        end
    end

    // AR channel slave
    initial forever begin
        @(negedge clk);
        if (!rst_n || !bus.m_axi_arvalid) begin
            bus.m_axi_arready = 1'b0;
            ar_cnt = 0;
        end else if (ar_cnt >= ar_wait) begin
            if (!bus.m_axi_arready) begin
                if (ar_exp_q.size() == 0) fail("ar_unexpected");
                else check("araddr", bus.m_axi_araddr, ar_exp_q.pop_front());
                check("arprot", bus.m_axi_arprot, 3'b000);
            end
            bus.m_axi_arready = 1'b1;
        end else begin
            bus.m_axi_arready = 1'b0;
            ar_cnt++;
        end
    end

    // B channel slave: answers b_wait cycles after bready, drops once bready falls
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            bus.m_axi_bvalid = 1'b0;
            b_cnt = 0;
        end else if (bus.m_axi_bvalid) begin
            if (!bus.m_axi_bready) begin
                bus.m_axi_bvalid = 1'b0;
                b_cnt = 0;
            end
        end else if (bus.m_axi_bready) begin
            if (b_cnt >= b_wait) begin
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = bresp_cfg;
            end else begin
                b_cnt++;
            end
        end
    end

    // R channel slave
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            bus.m_axi_rvalid = 1'b0;
            r_cnt = 0;
        end else if (bus.m_axi_rvalid) begin
            if (!bus.m_axi_rready) begin
                bus.m_axi_rvalid = 1'b0;
                r_cnt = 0;
            end
        end else if (bus.m_axi_rready) begin
            if (r_cnt >= r_wait) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rdata  = rdata_cfg;
                bus.m_axi_rresp  = rresp_cfg;
            end else begin
                r_cnt++;
            end
        end
    end

    // valid-hold lengths, payload stability, bready ordering
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            aw_hi = 0;
            w_hi  = 0;
            ar_hi = 0;
        end else begin
            if (bus.m_axi_awvalid) begin
                if (aw_hi == 0) aw_first = bus.m_axi_awaddr;
                else check("awaddr_stable", bus.m_axi_awaddr, aw_first);
                aw_hi++;
            end else if (aw_hi != 0) begin
                last_aw_hi = aw_hi;
                aw_hi = 0;
            end
            if (bus.m_axi_wvalid) begin
                if (w_hi == 0) w_first = bus.m_axi_wdata;
                else check("wdata_stable", bus.m_axi_wdata, w_first);
                w_hi++;
            end else if (w_hi != 0) begin
                last_w_hi = w_hi;
                w_hi = 0;
            end
            if (bus.m_axi_arvalid) begin
                if (ar_hi == 0) ar_first = bus.m_axi_araddr;
                else check("araddr_stable", bus.m_axi_araddr, ar_first);
                ar_hi++;
            end else if (ar_hi != 0) begin
                last_ar_hi = ar_hi;
                ar_hi = 0;
            end
            if (bus.m_axi_bready)
                check("bready_before_aw_w_done", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b00);
        end
    end

    // response monitor: pops the scoreboard on every rsp handshake
    logic          rsp_seen = 1'b0;
    int            rsp_first = 0;
    logic [DW+2:0] exp_e;
    int            exp_l;
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            rsp_seen = 1'b0;
        end else if (bus.rsp_valid) begin
            if (!rsp_seen) begin
                rsp_seen  = 1'b1;
                rsp_first = cyc;
            end
            if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    exp_e = exp_q.pop_front();
                    exp_l = lat_q.pop_front();
                    check("rsp_write", bus.rsp_write, exp_e[DW+2]);
                    check("rsp_rdata", bus.rsp_rdata, exp_e[DW+1:2]);
                    check("rsp_resp", bus.rsp_resp, exp_e[1:0]);
                    if (exp_l > 0) check("rsp_latency", rsp_first - hs_cyc, exp_l);
                end
                rsp_seen = 1'b0;
                n_rsp++;
            end
        end
    end

    // called at a negedge; returns at a negedge after the command handshake
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input logic [DW-1:0] exp_rdata,
                          input logic [1:0] exp_resp, input int exp_lat);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = wstrb;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            fail("cmd_accept_timeout");
            bus.cmd_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        if (wr) begin
            aw_exp_q.push_back(addr);
            w_exp_q.push_back({wstrb, wdata});
        end else begin
            ar_exp_q.push_back(addr);
        end
        exp_q.push_back({wr, exp_rdata, exp_resp});
        lat_q.push_back(exp_lat);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("response_timeout");
    endtask

    logic [DW+2:0] held;
    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        bus.rsp_ready = 1'b1;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);
        check("idle_state", dbg_state, 3'd0);

        // basic write, zero-wait slave
        do_cmd(1'b1, 4'h4, 32'h0000_0021, 4'hF, 32'h0, 2'b00, 4);
        wait_idle();

        // AW stalled 3 cycles, W accepted at once
        aw_wait = 3;
        do_cmd(1'b1, 4'h8, 32'hA5A5_0001, 4'h3, 32'h0, 2'b00, 0);
        wait_idle();
        check("awvalid_hold_cycles", last_aw_hi, 4);
        check("wvalid_hold_cycles", last_w_hi, 1);
        aw_wait = 0;

        // read, data after 2 wait cycles
        r_wait = 2;
        rdata_cfg = 32'h0000_003F;
        do_cmd(1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_003F, 2'b00, 5);
        wait_idle();
        check("arvalid_hold_cycles", last_ar_hi, 1);
        r_wait = 1;

        // read with AR stalled 2 cycles
        ar_wait = 2;
        rdata_cfg = 32'h0BAD_F00D;
        do_cmd(1'b0, 4'hC, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 6);
        wait_idle();
        check("arvalid_stall_hold_cycles", last_ar_hi, 3);
        ar_wait = 0;

        // response back-pressure with a new command waiting
        bus.rsp_ready = 1'b0;
        rdata_cfg = 32'h1234_5678;
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 4);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) fail("stall_rsp_timeout");
        held = {bus.rsp_write, bus.rsp_rdata, bus.rsp_resp};
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 32'hDEAD_BEEF;
        bus.cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rsp_held_stable", {bus.rsp_write, bus.rsp_rdata, bus.rsp_resp}, held);
            check("rsp_valid_held", bus.rsp_valid, 1'b1);
            check("cmd_ready_while_busy", bus.cmd_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        bresp_cfg = 2'b11;
        @(negedge clk);
        check("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
        do_cmd(1'b1, 4'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b11, 0);
        wait_idle();
        bresp_cfg = 2'b00;

        // SLVERR on read passes through with data
        rresp_cfg = 2'b10;
        rdata_cfg = 32'hCAFE_F00D;
        do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 4);
        wait_idle();
        rresp_cfg = 2'b00;

        // reset while awvalid is pending
        aw_wait = 10;
        do_cmd(1'b1, 4'hC, 32'h0000_0077, 4'hF, 32'h0, 2'b00, 0);
        n = 0;
        while (!bus.m_axi_awvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.m_axi_awvalid) fail("awvalid_before_reset");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", all_outs(), 128'd0);
        exp_q.delete();
        lat_q.delete();
        aw_exp_q.delete();
        w_exp_q.delete();
        ar_exp_q.delete();
        aw_wait = 0;
        @(negedge clk);
        check("reset_held_outputs", all_outs(), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("post_reset_state", dbg_state, 3'd0);
        do_cmd(1'b1, 4'h4, 32'h0000_0055, 4'h1, 32'h0, 2'b00, 4);
        wait_idle();

        check("rsp_count", n_rsp, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
